stage_mem_ctrl: RTL and testbench
=================================

# stage_mem_ctrl

Parametrised memory-access pipeline stage between EX/MEM and MEM/WB that replaces the single-cycle, aligned-only MEM stage. It drives a request/grant/response data bus, so memory latency is arbitrary, and holds the pipeline with `stallreq` until the access completes. Misaligned accesses are either split into two bus beats or trapped. Data width is selectable (RV32/RV64). Non-memory ops pass through with zero latency.

## Interface
- `XLEN`, 32: register/bus width, 32 or 64; `NB` = XLEN/8 byte lanes.
- `ALLOW_MISALIGNED`, 1: 1 = split line-crossing accesses into two beats; 0 = raise `exc_o`.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `ex_valid` in 1: EX/MEM holds a valid op; inputs held stable while `stallreq`=1.
- `stall_i` in 1: downstream/ctrl stall; MEM/WB not accepting.
- `aluop` in `AluOpBus`: `EXE_LB/LH/LW/LBU/LHU/SB/SH/SW_OP`; plus `EXE_LWU/LD/SD_OP` when XLEN=64.
- `reg_waddr_i` in `RegAddrBus`, `we_i` in 1, `reg_wdata_i` in XLEN: writeback info from EX.
- `mem_addr_i` in XLEN: byte address; `rt_data` in XLEN: store data.
- `reg_waddr_o` out `RegAddrBus`, `we_o` out 1, `reg_wdata_o` out XLEN: to MEM/WB.
- `exc_o` out 1: access fault/misaligned trap for this op (`we_o` forced 0).
- `stallreq` out 1: hold IF..EX/MEM.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out XLEN (NB-aligned), `bus_sel` out NB, `bus_wdata` out XLEN.
- `bus_gnt` in 1, `bus_rvalid` in 1, `bus_rdata` in XLEN, `bus_err` in 1.

## Operation
- Size: B=1, H=2, W=4, D=8 bytes; `off` = addr mod NB; beat0 addr = addr with low log2(NB) bits cleared; crossing = off+size > NB; beat1 addr = beat0+NB, wrapping mod 2^XLEN.
- `bus_sel` beat0 = ((1<<size)-1) << off, truncated to NB; beat1 = ((1<<size)-1) >> (NB-off).
- `bus_wdata` = store data (low `size` bytes) rotated left by off*8, same for both beats.
- Load result = ({hi,lo} >> off*8) low `size` bytes, sign-extended for LB/LH/LW, zero-extended for LBU/LHU/LWU; on RV32, LW is unextended; lo/hi are captured beats, hi=0 if not split.
- Non-memory op or `ex_valid`=0: outputs = inputs, `stallreq`=0, no bus activity, state stays IDLE.
- FSM:
  - IDLE: mem op drives beat0 (`bus_req`=1) combinationally. gnt: store not crossing → DONE; store crossing → REQ1; load → WAIT0. No gnt → stay.
  - WAIT0: `bus_rvalid` captures lo; crossing → REQ1, else DONE.
  - REQ1: beat1 request; gnt: store → DONE, load → WAIT1.
  - WAIT1: `bus_rvalid` captures hi → DONE.
  - DONE: result valid, `stallreq`=0; `stall_i`=0 → IDLE, else hold (no reissue).
- `bus_err` with gnt (store) or rvalid (load): latch fault, skip remaining beat → DONE with `exc_o`=1, `we_o`=0.
- Crossing with `ALLOW_MISALIGNED`=0: IDLE issues nothing; `exc_o`=1, `we_o`=0, `stallreq`=0 same cycle.
- `stallreq`=1 whenever a mem op is in IDLE/WAIT0/REQ1/WAIT1.
- Stores: `reg_wdata_o`=0; `we_o`=`we_i`.

## Timing
- Reset: state IDLE, captured data/fault cleared; while `rst`=1 every output is 0 (`bus_req`, `stallreq`, `we_o`, `exc_o`, data/addr/sel). Reset mid-transaction drops `bus_req` that cycle and discards any later `bus_rvalid`.
- `bus_req`/addr/sel/wdata/we stay stable until `bus_gnt`; at most one request per cycle; `bus_rvalid` earliest 1 cycle after grant.
- Aligned load, gnt at once, rvalid next cycle: stallreq cycles 0-1, result in cycle 2 (DONE).
- Aligned store, immediate gnt: DONE in cycle 1. Crossing load minimum: 5 cycles (IDLE, WAIT0, REQ1, WAIT1, DONE).
- Result outputs are combinational from DONE registers; pass-through ops have zero latency.

## Test plan
- XLEN=32, LW addr 0x100, gnt immediate, rvalid+1 with rdata 0xDEADBEEF → stallreq 2 cycles, DONE `reg_wdata_o`=0xDEADBEEF, `we_o`=1.
- LH addr 0x103, beat0 rdata 0x80AABBCC, beat1 rdata 0x11223344 → beat1 addr 0x104 with sel 0001 → result 0x00004480 (hi byte 0x44, lo byte 0x80); LB addr 0x103 on 0x80xxxxxx → 0xFFFFFF80.
- XLEN=64, SD addr 0x1004, data 0x0123456789ABCDEF → beat0 0x1000 sel 0xF0, beat1 0x1008 sel 0x0F, wdata 0x89ABCDEF01234567 both beats.
- SW addr 0xFFFFFFFE (XLEN=32) → beat1 addr 0x00000000 sel 0011 (wrap); `ALLOW_MISALIGNED`=0 same op → no `bus_req`, `exc_o`=1, `stallreq`=0.
- `bus_gnt` withheld 4 cycles, then `bus_err` on rvalid → request stable throughout; `exc_o`=1, `we_o`=0; `stall_i`=1 in DONE holds 3 cycles with no reissue.
- `rst` pulsed in WAIT0 → all outputs 0 next cycle; late `bus_rvalid` ignored; next LW completes normally.

Source files
------------

// File: rtl/stage_mem_ctrl_if.sv
// ============================================================================
// Module   : stage_mem_ctrl_if
// Purpose  : Request/grant/response data bus between stage_mem_ctrl and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface stage_mem_ctrl_if #(
  parameter int XLEN = 32
);
  localparam int NB = XLEN / 8;

  logic            bus_req;
  logic            bus_we;
  logic [XLEN-1:0] bus_addr;
  logic [NB-1:0]   bus_sel;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_gnt;
  logic            bus_rvalid;
  logic [XLEN-1:0] bus_rdata;
  logic            bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata, bus_err
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata, bus_err
  );
endinterface

`default_nettype wire

// File: rtl/stage_mem_ctrl.sv
// ============================================================================
// Module   : stage_mem_ctrl
// Purpose  : MEM pipeline stage with variable-latency bus, misaligned split/trap.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stage_mem_ctrl #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            rst,
  input  wire logic            ex_valid,
  input  wire logic            stall_i,
  input  wire logic [7:0]      aluop,
  input  wire logic [4:0]      reg_waddr_i,
  input  wire logic            we_i,
  input  wire logic [XLEN-1:0] reg_wdata_i,
  input  wire logic [XLEN-1:0] mem_addr_i,
  input  wire logic [XLEN-1:0] rt_data,
  output logic      [4:0]      reg_waddr_o,
  output logic                 we_o,
  output logic      [XLEN-1:0] reg_wdata_o,
  output logic                 exc_o,
  output logic                 stallreq,
  stage_mem_ctrl_if.master     bus
);

  localparam int NB  = XLEN / 8;
  localparam int LNB = $clog2(NB);

  localparam logic [7:0] EXE_LB_OP  = 8'h20;
  localparam logic [7:0] EXE_LH_OP  = 8'h21;
  localparam logic [7:0] EXE_LW_OP  = 8'h23;
  localparam logic [7:0] EXE_LBU_OP = 8'h24;
  localparam logic [7:0] EXE_LHU_OP = 8'h25;
  localparam logic [7:0] EXE_LWU_OP = 8'h26;
  localparam logic [7:0] EXE_LD_OP  = 8'h27;
  localparam logic [7:0] EXE_SB_OP  = 8'h28;
  localparam logic [7:0] EXE_SH_OP  = 8'h29;
  localparam logic [7:0] EXE_SW_OP  = 8'h2B;
  localparam logic [7:0] EXE_SD_OP  = 8'h2F;

  localparam logic [2*NB-1:0] ONE2 = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT0 = 3'd1,
    S_REQ1  = 3'd2,
    S_WAIT1 = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] lo_q, hi_q;
  logic            fault_q;

  logic            is_mem, is_load, is_signed, act, crossing, trap;
  logic [3:0]      sz;
  logic [LNB-1:0]  off;
  logic [LNB+2:0]  sh;
  logic [2*NB-1:0] mask2;
  logic [XLEN-1:0] beat0_addr, beat1_addr, sdat, wrot, ld_v, ld_l, ld_res;
  logic [2*XLEN-1:0] wd2, ld_cat;
  logic signed [XLEN-1:0] ld_s;
  logic [6:0]      ld_sh;

  always_comb begin
    is_mem    = 1'b0;
    is_load   = 1'b0;
    is_signed = 1'b0;
    sz        = 4'd0;
    case (aluop)
      EXE_LB_OP:  begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; sz = 4'd1; end
      EXE_LH_OP:  begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; sz = 4'd2; end
      EXE_LW_OP:  begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; sz = 4'd4; end
      EXE_LBU_OP: begin is_mem = 1'b1; is_load = 1'b1; sz = 4'd1; end
      EXE_LHU_OP: begin is_mem = 1'b1; is_load = 1'b1; sz = 4'd2; end
      EXE_SB_OP:  begin is_mem = 1'b1; sz = 4'd1; end
      EXE_SH_OP:  begin is_mem = 1'b1; sz = 4'd2; end
      EXE_SW_OP:  begin is_mem = 1'b1; sz = 4'd4; end
      EXE_LWU_OP: if (XLEN == 64) begin is_mem = 1'b1; is_load = 1'b1; sz = 4'd4; end
      EXE_LD_OP:  if (XLEN == 64) begin is_mem = 1'b1; is_load = 1'b1; is_signed = 1'b1; sz = 4'd8; end
      EXE_SD_OP:  if (XLEN == 64) begin is_mem = 1'b1; sz = 4'd8; end
      default: ;
    endcase
  end

  // Address split, lane select and store-data rotation
  always_comb begin
    act        = ex_valid & is_mem;
    off        = mem_addr_i[LNB-1:0];
    sh         = {off, 3'b000};
    crossing   = (5'(off) + 5'(sz)) > 5'(NB);
    trap       = crossing & ~ALLOW_MISALIGNED;
    beat0_addr = {mem_addr_i[XLEN-1:LNB], {LNB{1'b0}}};
    beat1_addr = beat0_addr + XLEN'(NB);
    mask2      = ((ONE2 << sz) - ONE2) << off;
    sdat       = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < int'(sz)) sdat[b*8 +: 8] = rt_data[b*8 +: 8];
    end
    wd2  = {sdat, sdat} << sh;
    wrot = wd2[2*XLEN-1:XLEN];
  end

  // Load result: shift the captured beat pair down, then extend from the access size
  always_comb begin
    ld_cat = {hi_q, lo_q} >> sh;
    ld_v   = ld_cat[XLEN-1:0];
    ld_sh  = 7'(XLEN) - {sz, 3'b000};
    ld_l   = ld_v << ld_sh;
    ld_s   = $signed(ld_l) >>> ld_sh;
    if (is_signed) ld_res = ld_s;
    else           ld_res = ld_l >> ld_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (act && !trap && bus.bus_gnt) begin
            lo_q    <= '0;
            hi_q    <= '0;
            fault_q <= 1'b0;
            if (is_load) begin
              state_q <= S_WAIT0;
            end else if (bus.bus_err) begin
              fault_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= crossing ? S_REQ1 : S_DONE;
            end
          end
        end
        S_WAIT0: begin
          if (bus.bus_rvalid) begin
            lo_q <= bus.bus_rdata;
            if (bus.bus_err) begin
              fault_q <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= crossing ? S_REQ1 : S_DONE;
            end
          end
        end
        S_REQ1: begin
          if (bus.bus_gnt) begin
            if (is_load)          state_q <= S_WAIT1;
            else begin
              if (bus.bus_err) fault_q <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_WAIT1: begin
          if (bus.bus_rvalid) begin
            hi_q <= bus.bus_rdata;
            if (bus.bus_err) fault_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!stall_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_waddr_o   = reg_waddr_i;
    we_o          = we_i;
    reg_wdata_o   = reg_wdata_i;
    exc_o         = 1'b0;
    stallreq      = 1'b0;
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_sel   = '0;
    bus.bus_wdata = '0;
    if (!(state_q == S_IDLE && !act)) begin
      we_o        = 1'b0;
      reg_wdata_o = '0;
      case (state_q)
        S_IDLE: begin
          if (trap) begin
            exc_o = 1'b1;
          end else begin
            stallreq      = 1'b1;
            bus.bus_req   = 1'b1;
            bus.bus_we    = ~is_load;
            bus.bus_addr  = beat0_addr;
            bus.bus_sel   = mask2[NB-1:0];
            bus.bus_wdata = is_load ? '0 : wrot;
          end
        end
        S_REQ1: begin
          stallreq      = 1'b1;
          bus.bus_req   = 1'b1;
          bus.bus_we    = ~is_load;
          bus.bus_addr  = beat1_addr;
          bus.bus_sel   = mask2[2*NB-1:NB];
          bus.bus_wdata = is_load ? '0 : wrot;
        end
        S_DONE: begin
          exc_o = fault_q;
          we_o  = we_i & ~fault_q;
          if (is_load && !fault_q) reg_wdata_o = ld_res;
        end
        default: stallreq = 1'b1;
      endcase
    end
    if (rst) begin
      reg_waddr_o   = '0;
      we_o          = 1'b0;
      reg_wdata_o   = '0;
      exc_o         = 1'b0;
      stallreq      = 1'b0;
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = '0;
      bus.bus_sel   = '0;
      bus.bus_wdata = '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stage_mem_ctrl.sv
// ============================================================================
// Module   : tb_stage_mem_ctrl
// Purpose  : Directed self-checking bench for stage_mem_ctrl (RV32, RV64, trap variant).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_stage_mem_ctrl;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LB  = 8'h20;
  localparam logic [7:0] OP_LH  = 8'h21;
  localparam logic [7:0] OP_LW  = 8'h23;
  localparam logic [7:0] OP_LBU = 8'h24;
  localparam logic [7:0] OP_SW  = 8'h2B;
  localparam logic [7:0] OP_SD  = 8'h2F;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int nvec  = 0;
  int nfail = 0;

  // RV32 stimulus, shared by the split and the trap variants
  logic        ex_valid, stall_i, we_i;
  logic [7:0]  aluop;
  logic [4:0]  waddr;
  logic [31:0] wdata, addr, rt;

  logic [4:0]  waddr_a, waddr_n;
  logic        we_a, exc_a, stq_a, we_n, exc_n, stq_n;
  logic [31:0] wdata_a, wdata_n;

  logic        ev64, we64;
  logic [7:0]  op64;
  logic [4:0]  waddr64;
  logic [63:0] wdata64, addr64, rt64;
  logic [4:0]  waddr_c;
  logic        we_c, exc_c, stq_c;
  logic [63:0] wdata_c;

  stage_mem_ctrl_if #(.XLEN(32)) bif_a ();
  stage_mem_ctrl_if #(.XLEN(32)) bif_n ();
  stage_mem_ctrl_if #(.XLEN(64)) bif_c ();

  stage_mem_ctrl #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall_i(stall_i), .aluop(aluop),
    .reg_waddr_i(waddr), .we_i(we_i), .reg_wdata_i(wdata), .mem_addr_i(addr), .rt_data(rt),
    .reg_waddr_o(waddr_a), .we_o(we_a), .reg_wdata_o(wdata_a), .exc_o(exc_a),
    .stallreq(stq_a), .bus(bif_a)
  );

  stage_mem_ctrl #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_n (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .stall_i(stall_i), .aluop(aluop),
    .reg_waddr_i(waddr), .we_i(we_i), .reg_wdata_i(wdata), .mem_addr_i(addr), .rt_data(rt),
    .reg_waddr_o(waddr_n), .we_o(we_n), .reg_wdata_o(wdata_n), .exc_o(exc_n),
    .stallreq(stq_n), .bus(bif_n)
  );

  stage_mem_ctrl #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_c (
    .clk(clk), .rst(rst), .ex_valid(ev64), .stall_i(stall_i), .aluop(op64),
    .reg_waddr_i(waddr64), .we_i(we64), .reg_wdata_i(wdata64), .mem_addr_i(addr64), .rt_data(rt64),
    .reg_waddr_o(waddr_c), .we_o(we_c), .reg_wdata_o(wdata_c), .exc_o(exc_c),
    .stallreq(stq_c), .bus(bif_c)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Aligned single-beat RV32 load: grant at once, rvalid next cycle; ends sampling DONE
  task automatic load32(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    aluop = op; addr = a; bif_a.bus_gnt = 1'b1;
    step();
    bif_a.bus_gnt = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = rd;
    step();
    bif_a.bus_rvalid = 1'b0; bif_a.bus_rdata = '0;
    smp();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ex_valid = 1'b1; stall_i = 1'b0; aluop = OP_LW; waddr = 5'd3; we_i = 1'b1;
    wdata = 32'h1111_2222; addr = 32'h100; rt = '0;
    bif_a.bus_gnt = 1'b1; bif_a.bus_rvalid = 1'b0; bif_a.bus_rdata = '0; bif_a.bus_err = 1'b0;
    bif_n.bus_gnt = 1'b0; bif_n.bus_rvalid = 1'b0; bif_n.bus_rdata = '0; bif_n.bus_err = 1'b0;
    bif_c.bus_gnt = 1'b0; bif_c.bus_rvalid = 1'b0; bif_c.bus_rdata = '0; bif_c.bus_err = 1'b0;
    ev64 = 1'b0; we64 = 1'b0; op64 = OP_NOP; waddr64 = '0; wdata64 = '0; addr64 = '0; rt64 = '0;

    // Reset forces every output low even with a live op
    smp();
    chk("rst_req",     bif_a.bus_req, 0);
    chk("rst_stall",   stq_a, 0);
    chk("rst_we",      we_a, 0);
    chk("rst_wdata",   wdata_a, 0);
    chk("rst_addr",    bif_a.bus_addr, 0);
    chk("rst_sel",     bif_a.bus_sel, 0);
    step();

    // Pass-through
    rst = 1'b0; bif_a.bus_gnt = 1'b0; aluop = OP_NOP; waddr = 5'd5; wdata = 32'h1234_5678; we_i = 1'b1;
    smp();
    chk("pass_wdata",  wdata_a, 32'h1234_5678);
    chk("pass_we",     we_a, 1);
    chk("pass_waddr",  waddr_a, 5);
    chk("pass_stall",  stq_a, 0);
    chk("pass_req",    bif_a.bus_req, 0);
    step();

    // Aligned LW
    aluop = OP_LW; addr = 32'h100; waddr = 5'd7; bif_a.bus_gnt = 1'b1;
    smp();
    chk("lw_req",      bif_a.bus_req, 1);
    chk("lw_addr",     bif_a.bus_addr, 32'h100);
    chk("lw_sel",      bif_a.bus_sel, 4'hF);
    chk("lw_buswe",    bif_a.bus_we, 0);
    chk("lw_stall0",   stq_a, 1);
    step();
    bif_a.bus_gnt = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 32'hDEAD_BEEF;
    smp();
    chk("lw_stall1",   stq_a, 1);
    chk("lw_req1",     bif_a.bus_req, 0);
    step();
    bif_a.bus_rvalid = 1'b0; bif_a.bus_rdata = '0;
    smp();
    chk("lw_stall2",   stq_a, 0);
    chk("lw_res",      wdata_a, 32'hDEAD_BEEF);
    chk("lw_we",       we_a, 1);
    chk("lw_exc",      exc_a, 0);
    step();

    // Line-crossing LH
    aluop = OP_LH; addr = 32'h103; bif_a.bus_gnt = 1'b1;
    smp();
    chk("lh_addr0",    bif_a.bus_addr, 32'h100);
    chk("lh_sel0",     bif_a.bus_sel, 4'b1000);
    step();
    bif_a.bus_gnt = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 32'h80AA_BBCC;
    smp();
    chk("lh_wait0",    stq_a, 1);
    step();
    bif_a.bus_rvalid = 1'b0; bif_a.bus_gnt = 1'b1;
    smp();
    chk("lh_req1",     bif_a.bus_req, 1);
    chk("lh_addr1",    bif_a.bus_addr, 32'h104);
    chk("lh_sel1",     bif_a.bus_sel, 4'b0001);
    step();
    bif_a.bus_gnt = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 32'h1122_3344;
    smp();
    chk("lh_wait1",    stq_a, 1);
    step();
    bif_a.bus_rvalid = 1'b0;
    smp();
    chk("lh_res",      wdata_a, 32'h0000_4480);
    chk("lh_stall",    stq_a, 0);
    step();

    // Byte loads, signed and unsigned
    load32(OP_LB, 32'h103, 32'h8011_2233);
    chk("lb_res",      wdata_a, 32'hFFFF_FF80);
    step();
    load32(OP_LBU, 32'h103, 32'h8011_2233);
    chk("lbu_res",     wdata_a, 32'h0000_0080);
    step();

    // SW wrapping past the top of memory; trap variant sees the same op
    aluop = OP_SW; addr = 32'hFFFF_FFFE; rt = 32'hAABB_CCDD; we_i = 1'b1; bif_a.bus_gnt = 1'b1;
    smp();
    chk("sw_addr0",    bif_a.bus_addr, 32'hFFFF_FFFC);
    chk("sw_sel0",     bif_a.bus_sel, 4'b1100);
    chk("sw_wd0",      bif_a.bus_wdata, 32'hCCDD_AABB);
    chk("sw_buswe",    bif_a.bus_we, 1);
    chk("nm_req",      bif_n.bus_req, 0);
    chk("nm_exc",      exc_n, 1);
    chk("nm_stall",    stq_n, 0);
    chk("nm_we",       we_n, 0);
    step();
    smp();
    chk("sw_addr1",    bif_a.bus_addr, 32'h0000_0000);
    chk("sw_sel1",     bif_a.bus_sel, 4'b0011);
    chk("sw_wd1",      bif_a.bus_wdata, 32'hCCDD_AABB);
    step();
    bif_a.bus_gnt = 1'b0;
    smp();
    chk("sw_stall",    stq_a, 0);
    chk("sw_rwd",      wdata_a, 0);
    chk("sw_we",       we_a, 1);
    step();

    // Grant withheld, then error on the response, then downstream stall in DONE
    aluop = OP_LW; addr = 32'h200; we_i = 1'b1; bif_a.bus_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("gw_req",    bif_a.bus_req, 1);
      chk("gw_addr",   bif_a.bus_addr, 32'h200);
      chk("gw_stall",  stq_a, 1);
      step();
    end
    bif_a.bus_gnt = 1'b1;
    step();
    bif_a.bus_gnt = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_err = 1'b1;
    bif_a.bus_rdata = 32'h1234_5678; stall_i = 1'b1;
    step();
    bif_a.bus_rvalid = 1'b0; bif_a.bus_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("err_exc",   exc_a, 1);
      chk("err_we",    we_a, 0);
      chk("err_req",   bif_a.bus_req, 0);
      chk("err_stall", stq_a, 0);
      step();
    end
    stall_i = 1'b0;
    step();

    // Reset while waiting for a response
    aluop = OP_LW; addr = 32'h300; bif_a.bus_gnt = 1'b1;
    step();
    bif_a.bus_gnt = 1'b0; rst = 1'b1;
    smp();
    chk("rs_req",      bif_a.bus_req, 0);
    chk("rs_stall",    stq_a, 0);
    chk("rs_exc",      exc_a, 0);
    chk("rs_we",       we_a, 0);
    step();
    rst = 1'b0; ex_valid = 1'b0; bif_a.bus_rvalid = 1'b1; bif_a.bus_rdata = 32'h0000_0055;
    smp();
    chk("rs_late_stall", stq_a, 0);
    chk("rs_late_req",   bif_a.bus_req, 0);
    step();
    bif_a.bus_rvalid = 1'b0; ex_valid = 1'b1;
    smp();
    chk("rs_idle_stall", stq_a, 1);
    load32(OP_LW, 32'h300, 32'hCAFE_F00D);
    chk("rs_next_res", wdata_a, 32'hCAFE_F00D);
    chk("rs_next_we",  we_a, 1);
    step();
    ex_valid = 1'b0;

    // RV64 crossing SD
    ev64 = 1'b1; op64 = OP_SD; addr64 = 64'h1004; rt64 = 64'h0123_4567_89AB_CDEF; bif_c.bus_gnt = 1'b1;
    smp();
    chk("sd_addr0",    bif_c.bus_addr, 64'h1000);
    chk("sd_sel0",     bif_c.bus_sel, 8'hF0);
    chk("sd_wd0",      bif_c.bus_wdata, 64'h89AB_CDEF_0123_4567);
    step();
    smp();
    chk("sd_addr1",    bif_c.bus_addr, 64'h1008);
    chk("sd_sel1",     bif_c.bus_sel, 8'h0F);
    chk("sd_wd1",      bif_c.bus_wdata, 64'h89AB_CDEF_0123_4567);
    step();
    bif_c.bus_gnt = 1'b0;
    smp();
    chk("sd_stall",    stq_c, 0);
    step();

    // RV64 LW sign-extends from the upper word lanes
    op64 = OP_LW; addr64 = 64'h2004; we64 = 1'b1; bif_c.bus_gnt = 1'b1;
    step();
    bif_c.bus_gnt = 1'b0; bif_c.bus_rvalid = 1'b1; bif_c.bus_rdata = 64'h8000_0001_0000_0000;
    step();
    bif_c.bus_rvalid = 1'b0;
    smp();
    chk("lw64_res",    wdata_c, 64'hFFFF_FFFF_8000_0001);
    chk("lw64_we",     we_c, 1);
    step();
    ev64 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
